// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state type, address-width helper and constants for the register file.
package regfile_pkg;
    typedef enum logic {IDLE, SWEEP} state_e;
    localparam int REG_ZERO = 0;
    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/regfile_row.sv
// regfile_row: one storage word with synchronous clear, write enable and sweep-clear enable.
module regfile_row #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic             sweep_clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] q_q;
    always_ff @(posedge clk)
        q_q <= (clr_i || sweep_clr_i) ? '0 : we_i ? d_i : q_q;
    assign q_o = q_q;
endmodule

// File: rtl/regfile_param.sv
// regfile_param: 1W/2R register file with hardwired zero register, write-first bypass
// and a multi-cycle sweep engine that clears the file without global reset.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    localparam int AW = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             write_ctrl,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddrA,
    input  logic [AW-1:0]    raddrB,
    input  logic             oeA,
    input  logic             oeB,
    input  logic             sweep_start,
    output logic [WIDTH-1:0] outA,
    output logic [WIDTH-1:0] outB,
    output logic             busy,
    output logic             wr_dropped
);
    state_e                      state_q;
    logic [AW-1:0]               idx_q;
    logic                        wr_dropped_q;
    logic                        wr_req, wr_ok, byp_en;
    logic [DEPTH-1:0][WIDTH-1:0] mem;

    assign busy   = state_q == SWEEP;
    assign wr_req = write_ctrl && waddr != AW'(REG_ZERO);
    assign wr_ok  = wr_req && !busy;
    assign byp_en = write_ctrl && !busy;
    assign mem[0] = '0;

    for (genvar i = 1; i < DEPTH; i++) begin : g_row
        regfile_row #(.WIDTH(WIDTH)) u_row (
            .clk         (clk),
            .clr_i       (clr),
            .we_i        (wr_ok && waddr == AW'(i)),
            .sweep_clr_i (busy && idx_q == AW'(i)),
            .d_i         (wdata),
            .q_o         (mem[i])
        );
    end

    // Address 0 must not bypass, otherwise a discarded zero-register write would leak out.
    assign outA = (!oeA || raddrA == AW'(REG_ZERO)) ? '0 :
                  (byp_en && waddr == raddrA) ? wdata : mem[raddrA];
    assign outB = (!oeB || raddrB == AW'(REG_ZERO)) ? '0 :
                  (byp_en && waddr == raddrB) ? wdata : mem[raddrB];
    assign wr_dropped = wr_dropped_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= IDLE;
            idx_q        <= AW'(1);
            wr_dropped_q <= 1'b0;
        end else begin
            wr_dropped_q <= busy && wr_req;
            if (state_q == IDLE) begin
                state_q <= sweep_start ? SWEEP : IDLE;
                idx_q   <= AW'(1);
            end else begin
                state_q <= (idx_q == AW'(DEPTH - 1)) ? IDLE : SWEEP;
                idx_q   <= (idx_q == AW'(DEPTH - 1)) ? AW'(1) : idx_q + AW'(1);
            end
        end
    end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: vector table plus scoreboard checks for the default and a 16x8 register file.
module tb_regfile_param;
    localparam int A  = 5;
    localparam int PA = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          clr, write_ctrl, oeA, oeB, sweep_start, busy, wr_dropped;
    logic [A-1:0]  waddr, raddrA, raddrB;
    logic [31:0]   wdata, outA, outB;

    logic          p_clr, p_write_ctrl, p_oeA, p_oeB, p_sweep_start, p_busy, p_wr_dropped;
    logic [PA-1:0] p_waddr, p_raddrA, p_raddrB;
    logic [15:0]   p_wdata, p_outA, p_outB;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra, rb;
        logic        oa, ob;
        logic [31:0] ea, eb;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] ea, eb;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[10];

    regfile_param dut (
        .clk(clk), .clr(clr), .write_ctrl(write_ctrl), .waddr(waddr), .wdata(wdata),
        .raddrA(raddrA), .raddrB(raddrB), .oeA(oeA), .oeB(oeB), .sweep_start(sweep_start),
        .outA(outA), .outB(outB), .busy(busy), .wr_dropped(wr_dropped)
    );

    regfile_param #(.WIDTH(16), .DEPTH(8)) dut_p (
        .clk(clk), .clr(p_clr), .write_ctrl(p_write_ctrl), .waddr(p_waddr), .wdata(p_wdata),
        .raddrA(p_raddrA), .raddrB(p_raddrB), .oeA(p_oeA), .oeB(p_oeB), .sweep_start(p_sweep_start),
        .outA(p_outA), .outB(p_outB), .busy(p_busy), .wr_dropped(p_wr_dropped)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
        $fatal(1);
    end

    initial begin
        int n;
        exp_t e;
        clr = 1'b1; write_ctrl = 1'b0; waddr = '0; wdata = '0; raddrA = '0; raddrB = '0;
        oeA = 1'b1; oeB = 1'b1; sweep_start = 1'b0;
        p_clr = 1'b1; p_write_ctrl = 1'b0; p_waddr = '0; p_wdata = '0; p_raddrA = '0; p_raddrB = '0;
        p_oeA = 1'b1; p_oeB = 1'b1; p_sweep_start = 1'b0;
        repeat (2) tick;
        clr = 1'b0; p_clr = 1'b0;
        raddrA = 5'd5; raddrB = 5'd31;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_drop", wr_dropped, 0);
        chk("rst_outA", outA, 0);
        chk("rst_outB", outB, 0);
        chk("rst_p_busy", p_busy, 0);
        tick;

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  1'b1, 1'b1, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  1'b1, 1'b0, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  1'b1, 1'b1, 32'h0,        32'h0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  1'b1, 1'b1, 32'h0,        32'hDEADBEEF};
        vecs[4] = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd7,  1'b1, 1'b1, 32'h12345678, 32'h12345678};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd5,  1'b1, 1'b1, 32'h12345678, 32'hDEADBEEF};
        vecs[6] = '{1'b1, 5'd5,  32'h0BADF00D, 5'd5,  5'd7,  1'b1, 1'b1, 32'h0BADF00D, 32'h12345678};
        vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd1,  1'b1, 1'b1, 32'h0BADF00D, 32'h0};
        vecs[8] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd30, 5'd31, 1'b1, 1'b1, 32'h0,        32'hCAFEF00D};
        vecs[9] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 1'b0, 1'b1, 32'h0,        32'hCAFEF00D};

        for (int i = 0; i < 10; i++) begin
            write_ctrl = vecs[i].we; waddr = vecs[i].wa; wdata = vecs[i].wd;
            raddrA = vecs[i].ra; raddrB = vecs[i].rb; oeA = vecs[i].oa; oeB = vecs[i].ob;
            sbq.push_back('{$sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb});
            @(negedge clk);
            e = sbq.pop_front();
            chk({e.name, "_outA"}, outA, e.ea);
            chk({e.name, "_outB"}, outB, e.eb);
            chk({e.name, "_drop"}, wr_dropped, 0);
            tick;
        end
        write_ctrl = 1'b0; oeA = 1'b1; oeB = 1'b1;

        for (int i = 1; i < 32; i++) begin
            write_ctrl = 1'b1; waddr = A'(i); wdata = 32'h1000 + i;
            tick;
        end
        write_ctrl = 1'b0; raddrA = 5'd3;
        @(negedge clk);
        chk("fill_reg3", outA, 32'h1003);
        tick;

        sweep_start = 1'b1; write_ctrl = 1'b1; waddr = 5'd2; wdata = 32'h77; raddrA = 5'd2;
        @(negedge clk);
        chk("start_same_cycle_byp", outA, 32'h77);
        chk("busy_before_sweep", busy, 0);
        tick;
        sweep_start = 1'b0; write_ctrl = 1'b0; n = 0;
        while (busy && n < 100) begin
            n++;
            write_ctrl = (n == 2); waddr = 5'd3; wdata = 32'h55; raddrA = 5'd3;
            @(negedge clk);
            if (n == 2) chk("sweep_byp_off", outA, 32'h1003);
            if (n == 3) chk("drop_pulse", wr_dropped, 1);
            if (n == 4) chk("drop_clear", wr_dropped, 0);
            tick;
        end
        write_ctrl = 1'b0;
        chk("sweep_len", n, 31);
        for (int i = 0; i < 32; i++) begin
            raddrA = A'(i); raddrB = A'(31 - i);
            @(negedge clk);
            chk($sformatf("swept_A%0d", i), outA, 0);
            chk($sformatf("swept_B%0d", 31 - i), outB, 0);
            tick;
        end

        write_ctrl = 1'b1; waddr = 5'd20; wdata = 32'h2020; tick;
        waddr = 5'd25; wdata = 32'h2525; tick;
        write_ctrl = 1'b0; sweep_start = 1'b1; tick;
        sweep_start = 1'b0; n = 0;
        while (busy && n < 100) begin
            n++;
            clr = (n == 10);
            tick;
        end
        clr = 1'b0;
        chk("clr_abort_cycle", n, 10);
        @(negedge clk);
        chk("clr_busy", busy, 0);
        chk("clr_drop", wr_dropped, 0);
        for (int i = 0; i < 4; i++) begin
            raddrA = (i == 0) ? 5'd9 : (i == 1) ? 5'd20 : (i == 2) ? 5'd25 : 5'd31;
            raddrB = raddrA;
            @(negedge clk);
            chk($sformatf("clr_regA%0d", raddrA), outA, 0);
            chk($sformatf("clr_regB%0d", raddrB), outB, 0);
        end
        tick;
        write_ctrl = 1'b1; waddr = 5'd9; wdata = 32'hA5; tick;
        write_ctrl = 1'b0; raddrA = 5'd9;
        @(negedge clk);
        chk("post_clr_reg9", outA, 32'hA5);
        tick;

        p_write_ctrl = 1'b1; p_waddr = 3'd7; p_wdata = 16'hBEEF; tick;
        p_write_ctrl = 1'b0; p_raddrA = 3'd7; p_raddrB = 3'd0;
        @(negedge clk);
        chk("p_reg7", p_outA, 32'hBEEF);
        chk("p_reg0", p_outB, 0);
        tick;
        for (int i = 1; i < 8; i++) begin
            p_write_ctrl = 1'b1; p_waddr = PA'(i); p_wdata = 16'h0A00 + 16'(i);
            tick;
        end
        p_write_ctrl = 1'b0; p_sweep_start = 1'b1; tick;
        p_sweep_start = 1'b0; n = 0;
        while (p_busy && n < 100) begin
            n++;
            tick;
        end
        chk("p_sweep_len", n, 7);
        p_raddrA = 3'd7; p_raddrB = 3'd1;
        @(negedge clk);
        chk("p_swept7", p_outA, 0);
        chk("p_swept1", p_outB, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised register file: the successor to the fixed 32-bit, two-read-port register stage in the processor's register subsystem. It holds DEPTH words of WIDTH bits and has one write port and two read ports. Register 0 is hardwired to zero, and write-to-read bypass is built in. A multi-cycle sweep engine clears the whole file on request without asserting global reset. It sits between the decode stage (read addresses) and writeback (write port), and replaces the per-register tri-state output bussing with muxed read ports.

## Interface
- WIDTH, 32, bits per register.
- DEPTH, 32, number of registers; power of two, at least 4.
- AW, $clog2(DEPTH), address width; derived, not overridden.

- clk  in  1  single clock; all state changes on its rising edge.
- clr  in  1  reset, synchronous, active-high.
- write_ctrl  in  1  write request from writeback.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- raddrA  in  AW  read address, port A.
- raddrB  in  AW  read address, port B.
- oeA  in  1  port A output enable; when low, outA = 0 (driven, never Z).
- oeB  in  1  port B output enable; when low, outB = 0.
- sweep_start  in  1  one-cycle pulse that requests a full-file clear.
- outA  out  WIDTH  port A read data (combinational).
- outB  out  WIDTH  port B read data (combinational).
- busy  out  1  high while a sweep is in progress.
- wr_dropped  out  1  registered; pulses for one cycle when a write was discarded.

## Operation
- Storage: registers 1..DEPTH-1 are writable. Register 0 is not stored and always reads 0.
- Write: on a rising edge with write_ctrl=1, busy=0, clr=0 and waddr≠0, reg[waddr] <= wdata. A write to address 0 is silently ignored and does not set wr_dropped.
- Read: outX = oeX ? value : 0.
- Read value selection: 0 if raddrX=0. Otherwise, if write_ctrl=1, busy=0, waddr=raddrX, the bypass returns wdata in the same cycle (write-first). Otherwise the read returns reg[raddrX].
- Sweep FSM, states IDLE and SWEEP:
  - IDLE: sweep_start=1 → SWEEP, with the sweep index set to 1 and busy=1 from the next cycle.
  - SWEEP: each cycle reg[idx] <= 0 and idx increments. After the cycle that clears DEPTH-1, → IDLE and busy=0.
  - sweep_start is ignored while in SWEEP.
- While busy=1:
  - write_ctrl=1 with waddr≠0 is discarded, and wr_dropped=1 on the following cycle.
  - The bypass is disabled.
  - Reads return current contents, which may be partially cleared.
- Simultaneous events in IDLE: sweep_start and write_ctrl in the same cycle. The write commits, because busy is still 0, and the sweep then clears it.
- clr: has priority over everything. On the next edge all registers are 0, the FSM is IDLE, the index is 1, busy=0 and wr_dropped=0. clr asserted mid-sweep aborts the sweep, and the file ends fully cleared anyway.

## Timing
- Reset values: busy=0, wr_dropped=0. outA and outB are 0 after reset for any address.
- Read latency is zero (combinational from raddr, oe, and the bypass inputs). A write is visible through storage on the cycle after its edge, and through the bypass in the same cycle.
- A sweep lasts exactly DEPTH-1 cycles of busy=1, starting the cycle after sweep_start.
- wr_dropped has a latency of 1 cycle from the discarded request.

## Structure
- regfile_pkg holds:
  - the state enum (IDLE, SWEEP);
  - the function deriving AW from DEPTH;
  - the REG_ZERO address constant (0).
- Sub-module regfile_row: one WIDTH-bit register with a synchronous clear, a write enable, and a sweep-clear enable, instantiated DEPTH-1 times with a generate loop.
- Read muxes, bypass compare, and the FSM live in the top module. There are no tri-states anywhere.

## Test plan
- Write and read: write reg5=0xDEADBEEF. Next cycle, raddrA=5, oeA=1 → outA=0xDEADBEEF. With oeA=0 → outA=0.
- Zero register: write_ctrl with waddr=0, wdata=0xFFFFFFFF. Then raddrB=0 → outB=0, and wr_dropped stays 0.
- Bypass: write_ctrl=1, waddr=7, wdata=0x12345678, raddrA=raddrB=7, all in the same cycle → both outputs are 0x12345678 that cycle.
- Sweep: fill all registers, pulse sweep_start. Check busy is high for exactly DEPTH-1 cycles (31 at the defaults). A write to reg3 mid-sweep → wr_dropped pulses and reg3=0 afterwards. All reads return 0 after busy falls.
- Reset mid-sweep: assert clr on the 10th sweep cycle → next cycle busy=0 and all registers read 0. A subsequent write to reg9=0xA5 → reads back 0xA5.
- Parameter check: WIDTH=16, DEPTH=8. Sweep lasts 7 cycles. Write to reg7=0xBEEF reads back 0xBEEF.
